// File: rtl/img_pkg.sv
// Shared definitions for the image-pipeline line-window sequencer.
package img_pkg;

  // Sequencer states; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL0  = 3'd1,
    FILL1  = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEFAULT_IMG_W = 800;
  localparam int DEFAULT_IMG_H = 600;

  // Cycles from a qualifying pixel to its 3x3 window appearing at the output.
  localparam int WIN_LAT = 3;

endpackage

// File: rtl/line_window_coord_pipe.sv
// Fixed-latency shift register carrying window valid, centre coordinates and
// the row-end / frame-end flags. A synchronous flush drops everything in flight.
module line_window_coord_pipe #(
  parameter int CW    = 16,
  parameter int DEPTH = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  input  logic          in_line_last,
  input  logic          in_frame_last,
  output logic          out_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          out_line_last,
  output logic          out_frame_last
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] ll_q;
  logic [DEPTH-1:0] fl_q;
  logic [CW-1:0]    x_q [DEPTH];
  logic [CW-1:0]    y_q [DEPTH];

  // Shift every cycle (stall-free); flush clears only the qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      ll_q <= '0;
      fl_q <= '0;
      // NOTE: the coordinate stages are reset as well because the last stage
      // drives module outputs directly, which must read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample the value its
      // neighbour held before this edge, giving a true shift register.
      for (int i = DEPTH - 1; i > 0; i--) begin
        v_q[i]  <= v_q[i-1] & ~flush;
        ll_q[i] <= ll_q[i-1] & ~flush;
        fl_q[i] <= fl_q[i-1] & ~flush;
        x_q[i]  <= x_q[i-1];
        y_q[i]  <= y_q[i-1];
      end
      v_q[0]  <= in_valid & ~flush;
      ll_q[0] <= in_line_last & ~flush;
      fl_q[0] <= in_frame_last & ~flush;
      x_q[0]  <= in_x;
      y_q[0]  <= in_y;
    end
  end

  assign out_valid      = v_q[DEPTH-1];
  assign out_x          = x_q[DEPTH-1];
  assign out_y          = y_q[DEPTH-1];
  assign out_line_last  = ll_q[DEPTH-1];
  assign out_frame_last = fl_q[DEPTH-1];

endmodule

// File: rtl/line_window_sched.sv
// Sequencer for the two-line-FIFO 3x3 window generator: tracks pixel column
// and row, drives the line-buffer enables and recirculation select, and
// qualifies windows with their centre coordinates.
module line_window_sched
  import img_pkg::*;
#(
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_vsync,
  input  logic          pix_valid,
  output logic          lb1_we,
  output logic          lb1_src_sel,
  output logic          lb2_we,
  output logic          lb_re,
  output logic          win_valid,
  output logic [CW-1:0] win_x,
  output logic [CW-1:0] win_y,
  output logic          line_end,
  output logic          frame_done,
  output logic          frame_err,
  output logic [2:0]    state_o
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  state_t        state, state_d, cur_state;
  logic [CW-1:0] col, col_d, cur_col;
  logic [CW-1:0] row, row_d, cur_row;
  logic          vsync_q, vsync_rise;
  logic          col_last;
  logic          fill_we_d, lb2_we_d, lb_re_d, recirc_d, err_d;
  logic          recirc_q;
  logic          pipe_valid, pipe_line_last, pipe_frame_last;
  logic [CW-1:0] pipe_x, pipe_y;
  logic          out_line_last, out_frame_last;

  assign vsync_rise = frame_vsync & ~vsync_q;

  // Next state, counters and enables. A vsync edge restarts the frame first,
  // so a pixel arriving with it is processed as col 0 / row 0 in FILL0.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned
    // (which would infer a latch).
    cur_state       = state;
    cur_col         = col;
    cur_row         = row;
    state_d         = state;
    col_d           = col;
    row_d           = row;
    col_last        = 1'b0;
    fill_we_d       = 1'b0;
    lb2_we_d        = 1'b0;
    lb_re_d         = 1'b0;
    recirc_d        = 1'b0;
    err_d           = 1'b0;
    pipe_valid      = 1'b0;
    pipe_x          = '0;
    pipe_y          = '0;
    pipe_line_last  = 1'b0;
    pipe_frame_last = 1'b0;

    if (vsync_rise) begin
      cur_state = FILL0;
      cur_col   = '0;
      cur_row   = '0;
      state_d   = FILL0;
      col_d     = '0;
      row_d     = '0;
      err_d     = (state == FILL1) || (state == STREAM);
    end

    if (pix_valid && cur_state != IDLE) begin
      if (cur_state == DONE) begin
        err_d = 1'b1;
      end else begin
        col_last = (cur_col == COL_LAST);
        col_d    = col_last ? '0 : cur_col + CW'(1);
        row_d    = col_last ? cur_row + CW'(1) : cur_row;
        case (cur_state)
          FILL0: begin
            fill_we_d = 1'b1;
            if (col_last) state_d = FILL1;
          end
          FILL1: begin
            lb2_we_d = 1'b1;
            if (col_last) state_d = STREAM;
          end
          STREAM: begin
            lb_re_d         = 1'b1;
            recirc_d        = 1'b1;
            lb2_we_d        = (cur_row < ROW_LAST);
            pipe_valid      = (cur_col >= CW'(2));
            pipe_x          = cur_col - CW'(1);
            pipe_y          = cur_row - CW'(1);
            pipe_line_last  = col_last;
            pipe_frame_last = col_last && (cur_row == ROW_LAST);
            if (pipe_frame_last) state_d = DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // State, counters and registered enables; recirculation is delayed one
  // extra cycle so it writes line buffer 2's read data back into line buffer 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      vsync_q     <= 1'b0;
      recirc_q    <= 1'b0;
      lb1_we      <= 1'b0;
      lb1_src_sel <= 1'b0;
      lb2_we      <= 1'b0;
      lb_re       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_d;
      col         <= col_d;
      row         <= row_d;
      vsync_q     <= frame_vsync;
      recirc_q    <= recirc_d;
      lb1_we      <= fill_we_d | (recirc_q & ~vsync_rise);
      lb1_src_sel <= recirc_q & ~vsync_rise & ~fill_we_d;
      lb2_we      <= lb2_we_d;
      lb_re       <= lb_re_d;
      frame_err   <= err_d;
    end
  end

  line_window_coord_pipe #(
    .CW    (CW),
    .DEPTH (WIN_LAT)
  ) u_coord_pipe (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (vsync_rise),
    .in_valid       (pipe_valid),
    .in_x           (pipe_x),
    .in_y           (pipe_y),
    .in_line_last   (pipe_line_last),
    .in_frame_last  (pipe_frame_last),
    .out_valid      (win_valid),
    .out_x          (win_x),
    .out_y          (win_y),
    .out_line_last  (out_line_last),
    .out_frame_last (out_frame_last)
  );

  assign line_end   = win_valid & out_line_last;
  assign frame_done = win_valid & out_frame_last;
  assign state_o    = state;

endmodule

// File: tb/tb_line_window_sched.sv
// Directed bench for line_window_sched: a 4x4 instance for the detailed
// scenarios and a 7x5 instance for a complete frame with gaps.
module tb_line_window_sched;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_vsync, pix_valid;
  logic          lb1_we, lb1_src_sel, lb2_we, lb_re;
  logic          win_valid, line_end, frame_done, frame_err;
  logic [CW-1:0] win_x, win_y;
  logic [2:0]    state_o;

  logic          b_vsync, b_pix;
  logic          b_lb1_we, b_lb1_src, b_lb2_we, b_lb_re;
  logic          b_win_valid, b_line_end, b_frame_done, b_frame_err;
  logic [CW-1:0] b_win_x, b_win_y;
  logic [2:0]    b_state;

  always #5 clk = ~clk;

  line_window_sched #(.IMG_W(4), .IMG_H(4), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .pix_valid(pix_valid),
    .lb1_we(lb1_we), .lb1_src_sel(lb1_src_sel), .lb2_we(lb2_we), .lb_re(lb_re),
    .win_valid(win_valid), .win_x(win_x), .win_y(win_y), .line_end(line_end),
    .frame_done(frame_done), .frame_err(frame_err), .state_o(state_o)
  );

  line_window_sched #(.IMG_W(7), .IMG_H(5), .CW(CW)) u_big (
    .clk(clk), .rst_n(rst_n), .frame_vsync(b_vsync), .pix_valid(b_pix),
    .lb1_we(b_lb1_we), .lb1_src_sel(b_lb1_src), .lb2_we(b_lb2_we), .lb_re(b_lb_re),
    .win_valid(b_win_valid), .win_x(b_win_x), .win_y(b_win_y), .line_end(b_line_end),
    .frame_done(b_frame_done), .frame_err(b_frame_err), .state_o(b_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitors (sampled on the falling edge) ----------------
  typedef struct {
    int            c;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          le;
    logic          fd;
  } win_t;

  win_t wq[$];
  int n_lb1, n_rc, n_lb2, n_re, n_err, n_fd;
  int first_lb1, first_rc, first_lb2;
  int pix_cyc[64];
  int pix_n;

  int b_nwin, b_nle, b_nfd, b_nerr, b_fd_ok;
  logic [CW-1:0] b_last_x, b_last_y;

  always @(negedge clk) begin
    if (win_valid) wq.push_back('{cyc, win_x, win_y, line_end, frame_done});
    if (lb1_we && !lb1_src_sel) begin n_lb1++; if (first_lb1 < 0) first_lb1 = cyc; end
    if (lb1_we && lb1_src_sel)  begin n_rc++;  if (first_rc < 0)  first_rc  = cyc; end
    if (lb2_we) begin n_lb2++; if (first_lb2 < 0) first_lb2 = cyc; end
    if (lb_re) n_re++;
    if (frame_err) n_err++;
    if (frame_done) n_fd++;
    if (b_win_valid) begin b_nwin++; b_last_x = b_win_x; b_last_y = b_win_y; end
    if (b_line_end) b_nle++;
    if (b_frame_err) b_nerr++;
    if (b_frame_done) begin b_nfd++; if (b_win_valid) b_fd_ok++; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_mon();
    wq.delete();
    n_lb1 = 0; n_rc = 0; n_lb2 = 0; n_re = 0; n_err = 0; n_fd = 0;
    first_lb1 = -1; first_rc = -1; first_lb2 = -1;
    pix_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    frame_vsync = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    frame_vsync = 1'b0;
  endtask

  // Drives n pixels (optionally with a one-cycle gap after each), recording
  // the cycle each pixel is presented; returns in the cycle after the last.
  task automatic send_pixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_cyc[pix_n] = cyc;
      pix_n++;
      if (gaps) begin
        @(posedge clk); #1;
        pix_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; frame_vsync = 1'b0; pix_valid = 1'b0; b_vsync = 1'b0; b_pix = 1'b0;
    #12;
    n_checks++;
    if ({lb1_we, lb1_src_sel, lb2_we, lb_re, win_valid, line_end, frame_done, frame_err} !== 8'h00 ||
        win_x !== '0 || win_y !== '0 || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b%b%b%b win=%b x=%0d y=%0d le=%b fd=%b err=%b st=%0d, want all 0",
               lb1_we, lb1_src_sel, lb2_we, lb_re, win_valid, win_x, win_y, line_end, frame_done, frame_err, state_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  // Shared body for the two 4x4 full-frame scenarios.
  task automatic run_4x4_frame(input bit gaps, input string tag);
    int exp_x[4]   = '{1, 2, 1, 2};
    int exp_y[4]   = '{1, 1, 2, 2};
    int exp_le[4]  = '{0, 1, 0, 1};
    int exp_fd[4]  = '{0, 0, 0, 1};
    int exp_pix[4] = '{10, 11, 14, 15};
    clear_mon();
    start_frame();
    send_pixels(16, gaps);
    idle(6);
    n_checks++;
    if (n_lb1 !== 4 || n_lb2 !== 8 || n_re !== 8 || n_rc !== 8) begin
      n_fail++;
      $display("FAIL %s_enable_counts: got lb1=%0d lb2=%0d re=%0d recirc=%0d, want 4 8 8 8", tag, n_lb1, n_lb2, n_re, n_rc);
    end
    n_checks++;
    if (first_lb1 !== pix_cyc[0] + 1 || first_lb2 !== pix_cyc[4] + 1 || first_rc !== pix_cyc[8] + 2) begin
      n_fail++;
      $display("FAIL %s_enable_timing: got lb1@%0d lb2@%0d rc@%0d, want %0d %0d %0d", tag,
               first_lb1, first_lb2, first_rc, pix_cyc[0] + 1, pix_cyc[4] + 1, pix_cyc[8] + 2);
    end
    n_checks++;
    if (wq.size() !== 4) begin
      n_fail++;
      $display("FAIL %s_win_count: got %0d, want 4", tag, wq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (int'(wq[k].x) !== exp_x[k] || int'(wq[k].y) !== exp_y[k] || wq[k].le !== 1'(exp_le[k]) ||
            wq[k].fd !== 1'(exp_fd[k]) || wq[k].c !== pix_cyc[exp_pix[k]] + 3) begin
          n_fail++;
          $display("FAIL %s_win%0d: got (%0d,%0d) le=%b fd=%b lat=%0d, want (%0d,%0d) le=%0d fd=%0d lat=3", tag, k,
                   wq[k].x, wq[k].y, wq[k].le, wq[k].fd, wq[k].c - pix_cyc[exp_pix[k]],
                   exp_x[k], exp_y[k], exp_le[k], exp_fd[k]);
        end
      end
    end
    n_checks++;
    if (n_fd !== 1 || n_err !== 0 || state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL %s_frame_end: got done=%0d err=%0d state=%0d, want 1 0 4", tag, n_fd, n_err, state_o);
    end
  endtask

  task automatic test_back_to_back();
    run_4x4_frame(1'b0, "b2b");
  endtask

  task automatic test_gaps();
    run_4x4_frame(1'b1, "gaps");
  endtask

  task automatic test_extra_after_done();
    clear_mon();
    send_pixels(1, 1'b0);
    idle(5);
    n_checks++;
    if (n_err !== 1 || (n_lb1 + n_rc + n_lb2 + n_re) !== 0 || wq.size() !== 0 || state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL extra_pixel: got err=%0d enables=%0d wins=%0d state=%0d, want 1 0 0 4",
               n_err, n_lb1 + n_rc + n_lb2 + n_re, wq.size(), state_o);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    start_frame();
    send_pixels(11, 1'b0);         // last pixel is row 2 col 2: a window is in flight
    frame_vsync = 1'b1;
    @(posedge clk); #1;
    frame_vsync = 1'b0;
    n_checks++;
    if (frame_err !== 1'b1 || state_o !== 3'd1 || dut.col !== '0 || dut.row !== '0) begin
      n_fail++;
      $display("FAIL abort_edge: got err=%b state=%0d col=%0d row=%0d, want 1 1 0 0",
               frame_err, state_o, dut.col, dut.row);
    end
    @(posedge clk); #1;
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_err_width: got err=%b one cycle later, want 0", frame_err);
    end
    idle(5);
    n_checks++;
    if (wq.size() !== 0 || n_err !== 1 || n_fd !== 0) begin
      n_fail++;
      $display("FAIL abort_flush: got wins=%0d err=%0d done=%0d, want 0 1 0", wq.size(), n_err, n_fd);
    end
  endtask

  task automatic test_reset_mid_stream();
    start_frame();
    send_pixels(11, 1'b0);
    n_checks++;
    if (lb_re !== 1'b1 || state_o !== 3'd3) begin
      n_fail++;
      $display("FAIL midstream_pre: got re=%b state=%0d, want 1 3", lb_re, state_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lb1_we, lb1_src_sel, lb2_we, lb_re, win_valid, line_end, frame_done, frame_err} !== 8'h00 ||
        win_x !== '0 || win_y !== '0 || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL midstream_async_reset: got en=%b%b%b%b win=%b x=%0d y=%0d st=%0d, want all 0",
               lb1_we, lb1_src_sel, lb2_we, lb_re, win_valid, win_x, win_y, state_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mon();
    send_pixels(8, 1'b0);
    idle(5);
    n_checks++;
    if (state_o !== 3'd0 || (n_lb1 + n_rc + n_lb2 + n_re + n_err) !== 0 || wq.size() !== 0) begin
      n_fail++;
      $display("FAIL post_reset_ignore: got state=%0d activity=%0d wins=%0d, want 0 0 0",
               state_o, n_lb1 + n_rc + n_lb2 + n_re + n_err, wq.size());
    end
  endtask

  // Starting from IDLE, the first pixel arrives on the vsync edge cycle and
  // must count as col 0 / row 0 of the new frame.
  task automatic test_vsync_with_pix();
    clear_mon();
    @(posedge clk); #1;
    frame_vsync = 1'b1; pix_valid = 1'b1;
    pix_cyc[0] = cyc; pix_n = 1;
    @(posedge clk); #1;
    frame_vsync = 1'b0;
    pix_cyc[1] = cyc; pix_n = 2;
    send_pixels(14, 1'b0);
    idle(6);
    n_checks++;
    if (n_lb1 !== 4 || first_lb1 !== pix_cyc[0] + 1 || n_err !== 0) begin
      n_fail++;
      $display("FAIL vsync_pix_fill: got lb1=%0d at %0d err=%0d, want 4 at %0d err 0",
               n_lb1, first_lb1, n_err, pix_cyc[0] + 1);
    end
    n_checks++;
    if (wq.size() !== 4 || n_fd !== 1 || state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL vsync_pix_frame: got wins=%0d done=%0d state=%0d, want 4 1 4", wq.size(), n_fd, state_o);
    end
  endtask

  task automatic test_large_frame();
    b_nwin = 0; b_nle = 0; b_nfd = 0; b_nerr = 0; b_fd_ok = 0;
    @(posedge clk); #1;
    b_vsync = 1'b1;
    @(posedge clk); #1;
    b_vsync = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      b_pix = 1'b1;
      if (i % 3 == 2) begin
        @(posedge clk); #1;
        b_pix = 1'b0;
      end
    end
    @(posedge clk); #1;
    b_pix = 1'b0;
    idle(6);
    n_checks++;
    if (b_nwin !== 15 || b_nle !== 3 || b_nfd !== 1 || b_fd_ok !== 1 || b_nerr !== 0) begin
      n_fail++;
      $display("FAIL big_counts: got wins=%0d le=%0d done=%0d done_with_win=%0d err=%0d, want 15 3 1 1 0",
               b_nwin, b_nle, b_nfd, b_fd_ok, b_nerr);
    end
    n_checks++;
    if (b_last_x !== 16'd5 || b_last_y !== 16'd3 || b_state !== 3'd4) begin
      n_fail++;
      $display("FAIL big_last_window: got (%0d,%0d) state=%0d, want (5,3) 4", b_last_x, b_last_y, b_state);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_back_to_back();
    test_extra_after_done();
    test_gaps();
    test_abort();
    test_reset_mid_stream();
    test_vsync_with_pix();
    test_large_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
